aes192_round_key_gearbox: RTL



---
 rtl/aes192_round_key_gearbox.sv | 117 +++++++++++
 1 files changed

// File: rtl/aes192_round_key_gearbox.sv
// AES-192 round-key gearbox: re-packs 6-word expanded-key groups
// into 13 4-word round keys tagged with their round index.
module aes192_round_key_gearbox (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic         busy_o,
  input  logic [191:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [127:0] rk_data_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         done_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q;
  logic   done_q;

  // Buffer of 9 words, oldest word in the top 32 bits.
  logic [287:0] buf_q, buf_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   gcnt_q, gcnt_d;
  logic [3:0]   rcnt_q, rcnt_d;

  logic         run;
  logic         accept;
  logic         emit;
  logic         last;
  logic [8:0]   sh;
  logic [287:0] keep;
  logic [287:0] incoming;

  assign run    = (state_q == RUN);
  assign accept = in_valid_i && in_ready_o;
  assign emit   = rk_valid_o && rk_ready_i;
  assign last   = emit && (rcnt_q == 4'd12);

  // New words land right behind the cnt words already held.
  assign sh       = {cnt_q, 5'd0};
  assign keep     = ~({288{1'b1}} >> sh);
  assign incoming = {in_data_i, 96'd0} >> sh;

  assign in_ready_o = run && (cnt_q <= 4'd3) && (gcnt_q < 4'd9);
  assign rk_valid_o = run && (cnt_q >= 4'd4);
  assign rk_data_o  = buf_q[287:160];
  assign rk_idx_o   = rcnt_q;
  assign busy_o     = run;
  assign done_o     = done_q;

  // Next-state of buffer and counters for accept / emit / start.
  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    gcnt_d = gcnt_q;
    rcnt_d = rcnt_q;
    if (!run) begin
      if (start_i) begin
        buf_d  = '0;
        cnt_d  = '0;
        gcnt_d = '0;
        rcnt_d = '0;
      end
    end else if (accept) begin
      buf_d  = (buf_q & keep) | incoming;
      cnt_d  = cnt_q + 4'd6;
      gcnt_d = gcnt_q + 4'd1;
    end else if (emit) begin
      rcnt_d = rcnt_q + 4'd1;
      if (last) begin
        // Leftover words 52/53 of the final group are dropped here.
        buf_d = '0;
        cnt_d = '0;
      end else begin
        buf_d = {buf_q[159:0], 128'd0};
        cnt_d = cnt_q - 4'd4;
      end
    end
  end

  // Buffer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      gcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      gcnt_q <= gcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Control FSM with registered end-of-schedule pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      unique case (state_q)
        IDLE: if (start_i) state_q <= RUN;
        RUN:  if (last)    state_q <= IDLE;
        default:           state_q <= IDLE;
      endcase
    end
  end

endmodule
